// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, register offsets, STATUS layout and frame builder.
// Used by ps2_host_tx and by the ps2_mouse receiver that shares CS_PS2.
package ps2_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam logic [1:0] REG_TXDATA = 2'b10;
    localparam logic [1:0] REG_STATUS = 2'b11;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    // Data, odd parity and stop bit; the start bit is driven separately during inhibit.
    localparam int FRAME_W = 10;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// 2-FF synchronizer plus falling-edge detect for one open-drain PS/2 line; sync_o lags the pin by 2 cycles,
// fall_o pulses 1 cycle on a synced 1->0 step. No backpressure; resets to idle-high so reset never fakes an edge.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-bit frame, device ACK check, STATUS readback.
// Clock goes low 1 cycle after an accepted write; writes while busy are dropped (no queueing).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_cs,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  addr,
    inout  wire  [15:0] databus,
    inout  wire         MOUSE_CLOCK,
    inout  wire         MOUSE_DATA,
    output logic        tx_active
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(FRAME_W - 1);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               clk_low_q, clk_low_d;
    logic               dat_low_q, dat_low_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               idle_seen_q, idle_seen_d;

    logic               clk_sync;
    logic               clk_fall;
    logic               dat_sync;
    logic               dat_fall_unused;
    logic               unused_bus_hi;

    logic               busy;
    logic               wr_accept;
    logic               status_rd;
    logic               timed;
    logic               timeout;
    logic [15:0]        status_w;

    // rst is active-low despite its name.
    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .rst_n  (rst),
        .line_i (MOUSE_CLOCK),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clk    (clk),
        .rst_n  (rst),
        .line_i (MOUSE_DATA),
        .sync_o (dat_sync),
        .fall_o (dat_fall_unused)
    );

    assign unused_bus_hi = ^databus[15:8];

    assign busy      = (state_q != ST_IDLE);
    assign tx_active = busy;
    assign wr_accept = io_cs & write & (addr == REG_TXDATA) & (state_q == ST_IDLE);
    assign status_rd = io_cs & read & (addr == REG_STATUS);
    assign timed     = (state_q == ST_REQ) | (state_q == ST_SEND) |
                       (state_q == ST_ACK) | (state_q == ST_WAIT_IDLE);
    assign timeout   = timed & (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        clk_low_d   = clk_low_q;
        dat_low_d   = dat_low_q;
        done_d      = done_q;
        err_d       = err_q;
        idle_seen_d = idle_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_accept) begin
                    frame_d   = build_frame(databus[7:0]);
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    clk_low_d = 1'b1;
                    dat_low_d = 1'b0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Start bit overlaps the final inhibit cycle so data is low before clock is released.
                if (cnt_q == INH_START) dat_low_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                bit_cnt_d = '0;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (clk_fall) begin
                    dat_low_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[FRAME_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (dat_sync) err_d = 1'b1;
                    idle_seen_d = 1'b0;
                    state_d     = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync & dat_sync) begin
                    if (idle_seen_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idle_seen_d = 1'b1;
                    end
                end else begin
                    idle_seen_d = 1'b0;
                end
            end
            default: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Timeout overrides whatever the protocol states decided this cycle, including an ACK sample.
        if (timed) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout) begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                err_d     = 1'b1;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            clk_low_q   <= 1'b0;
            dat_low_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            idle_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            clk_low_q   <= clk_low_d;
            dat_low_q   <= dat_low_d;
            done_q      <= done_d;
            err_q       <= err_d;
            idle_seen_q <= idle_seen_d;
        end
    end

    always_comb begin
        status_w            = '0;
        status_w[STAT_BUSY] = busy;
        status_w[STAT_DONE] = done_q;
        status_w[STAT_ERR]  = err_q;
    end

    assign databus     = status_rd ? status_w : 16'bz;
    assign MOUSE_CLOCK = clk_low_q ? 1'b0 : 1'bz;
    assign MOUSE_DATA  = dat_low_q ? 1'b0 : 1'bz;

endmodule
